// File: rtl/mem_map_pkg.sv
// Memory map shared by the responder and the core's address generation:
// FSM encoding, GPIO window location and register offsets, RAM region limit.
package mem_map_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [31:0] GPIO_BASE     = 32'h7FFF_0000;
  localparam logic [31:0] GPIO_IN_OFS   = 32'h0000_0000;
  localparam logic [31:0] GPIO_OUT_OFS  = 32'h0000_0004;
  localparam logic [31:0] GPIO_EDGE_OFS = 32'h0000_0008;

  // First byte address above the RAM region (RAM spans 4 * 2**addr_w bytes).
  function automatic logic [31:0] ram_limit(input int unsigned addr_w);
    return 32'd4 << addr_w;
  endfunction

endpackage

// File: rtl/gpio_sync_capture.sv
// Two-flop synchronizer for the switch inputs; with GPIO_EDGE_CAPTURE_EN it also
// keeps a sticky write-1-to-clear rising-edge capture register and a registered irq.
module gpio_sync_capture #(
  parameter int unsigned GPIO_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [GPIO_W-1:0] gpio_in,
`ifdef GPIO_EDGE_CAPTURE_EN
  input  logic              clr_en_i,
  input  logic [GPIO_W-1:0] clr_mask_i,
  output logic [GPIO_W-1:0] cap_o,
  output logic              irq_o,
`endif
  output logic [GPIO_W-1:0] sync_o
);
  import mem_map_pkg::*;

  logic [GPIO_W-1:0] meta_q;
  logic [GPIO_W-1:0] sync_q;

  // Synchronizer chain: meta_q may go metastable, sync_q is the usable value.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= {GPIO_W{1'b0}};
      sync_q <= {GPIO_W{1'b0}};
    end else begin
      meta_q <= gpio_in;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

`ifdef GPIO_EDGE_CAPTURE_EN
  logic [GPIO_W-1:0] prev_q;
  logic [GPIO_W-1:0] cap_q;
  logic [GPIO_W-1:0] cap_d;
  logic              irq_q;
  logic [GPIO_W-1:0] rise_s;

  assign rise_s = sync_q & ~prev_q;

  // Set wins over a simultaneous clear on the same bit.
  always_comb begin
    cap_d = cap_q;
    if (clr_en_i) begin
      cap_d = (cap_q & ~clr_mask_i) | rise_s;
    end else begin
      cap_d = cap_q | rise_s;
    end
  end

  // Edge history, capture register and interrupt flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= {GPIO_W{1'b0}};
      cap_q  <= {GPIO_W{1'b0}};
      irq_q  <= 1'b0;
    end else begin
      prev_q <= sync_q;
      cap_q  <= cap_d;
      irq_q  <= |cap_q;
    end
  end

  assign cap_o = cap_q;
  assign irq_o = irq_q;
`endif

endmodule

// File: rtl/mem_gpio_responder.sv
// Memory-mapped responder: word RAM, GPIO input port and GPIO output register
// behind a one-outstanding-request handshake. Optional GPIO_EDGE_CAPTURE_EN.
module mem_gpio_responder #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned WAIT_CYC  = 1,
  parameter int unsigned GPIO_W    = 8,
  parameter logic [31:0] GPIO_BASE = mem_map_pkg::GPIO_BASE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  input  logic [GPIO_W-1:0] gpio_in,
`ifdef GPIO_EDGE_CAPTURE_EN
  output logic              irq,
`endif
  output logic [GPIO_W-1:0] gpio_out
);
  import mem_map_pkg::*;

  if (WAIT_CYC > 15) begin : g_wait_cyc_range
    $error("mem_gpio_responder: WAIT_CYC must be in 0..15");
  end

  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;
  localparam logic [31:0] RAM_LIMIT = ram_limit(ADDR_W);
  localparam logic [31:0] GIN_ADDR  = GPIO_BASE + GPIO_IN_OFS;
  localparam logic [31:0] GOUT_ADDR = GPIO_BASE + GPIO_OUT_OFS;

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q;
  logic [29:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  logic              accept_s;
  logic              ram_we_s;
  logic              is_ram_s, is_gin_s, is_gout_s;
  logic [ADDR_W-1:0] ram_idx_s;
  logic [GPIO_W-1:0] gpio_sync_s;
  logic              cap_clr_s;
  logic              unused_addr_lsb_s;

  assign unused_addr_lsb_s = ^req_addr[1:0];

  assign is_ram_s  = ({addr_q, 2'b00} < RAM_LIMIT);
  assign is_gin_s  = (addr_q == GIN_ADDR[31:2]);
  assign is_gout_s = (addr_q == GOUT_ADDR[31:2]);
  assign ram_idx_s = addr_q[ADDR_W-1:0];

`ifdef GPIO_EDGE_CAPTURE_EN
  localparam logic [31:0] EDGE_ADDR = GPIO_BASE + GPIO_EDGE_OFS;
  logic              is_edge_s;
  logic [GPIO_W-1:0] cap_s;
  logic              irq_s;

  assign is_edge_s = (addr_q == EDGE_ADDR[31:2]);
  assign irq       = irq_s;
`endif

  gpio_sync_capture #(
    .GPIO_W (GPIO_W)
  ) u_gpio (
    .clk        (clk),
    .reset      (reset),
    .gpio_in    (gpio_in),
`ifdef GPIO_EDGE_CAPTURE_EN
    .clr_en_i   (cap_clr_s),
    .clr_mask_i (wdata_q[GPIO_W-1:0]),
    .cap_o      (cap_s),
    .irq_o      (irq_s),
`endif
    .sync_o     (gpio_sync_s)
  );

  // Handshake FSM plus the access itself, which happens only in RESP.
  always_comb begin
    state_d      = state_q;
    ready_d      = 1'b0;
    cnt_d        = cnt_q;
    accept_s     = 1'b0;
    resp_valid_d = 1'b0;
    rdata_d      = {DATA_W{1'b0}};
    err_d        = 1'b0;
    gpio_out_d   = gpio_out_q;
    ram_we_s     = 1'b0;
    cap_clr_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          accept_s = 1'b1;
          cnt_d    = WAIT_LOAD;
          state_d  = (WAIT_CYC > 0) ? ST_WAIT : ST_RESP;
          ready_d  = 1'b0;
        end else begin
          ready_d  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d      = ST_IDLE;
        ready_d      = 1'b1;
        resp_valid_d = 1'b1;
        if (is_ram_s) begin
          if (write_q) begin
            ram_we_s = 1'b1;
          end else begin
            rdata_d  = mem_q[ram_idx_s];
          end
        end else if (is_gin_s) begin
          // Writes to the input port are accepted and dropped.
          if (write_q) begin
            rdata_d = {DATA_W{1'b0}};
          end else begin
            rdata_d = DATA_W'(gpio_sync_s);
          end
        end else if (is_gout_s) begin
          if (write_q) begin
            gpio_out_d = wdata_q[GPIO_W-1:0];
          end else begin
            rdata_d    = DATA_W'(gpio_out_q);
          end
`ifdef GPIO_EDGE_CAPTURE_EN
        end else if (is_edge_s) begin
          if (write_q) begin
            cap_clr_s = 1'b1;
          end else begin
            rdata_d   = DATA_W'(cap_s);
          end
`endif
        end else begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b0;
      end
    endcase
  end

  // Control, request latch and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b0;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      addr_q       <= 30'd0;
      wdata_q      <= {DATA_W{1'b0}};
      resp_valid_q <= 1'b0;
      rdata_q      <= {DATA_W{1'b0}};
      err_q        <= 1'b0;
      gpio_out_q   <= {GPIO_W{1'b0}};
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      gpio_out_q   <= gpio_out_d;
      if (accept_s) begin
        write_q <= req_write;
        addr_q  <= req_addr[31:2];
        wdata_q <= req_wdata;
      end
    end
  end

  // RAM contents survive reset; a write landing on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (ram_we_s && !reset) begin
      mem_q[ram_idx_s] <= wdata_q;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign gpio_out   = gpio_out_q;

endmodule

// File: tb/tb_mem_gpio_responder.sv
// Self-checking bench for mem_gpio_responder: directed scenarios plus randomized
// traffic compared against a map-level model (RAM array, GPIO registers).
module tb_mem_gpio_responder;
  localparam int          WAIT_CYC = 1;
  localparam int          LAT_EXP  = WAIT_CYC + 1;
  localparam int          GAP_EXP  = WAIT_CYC + 2;
  localparam logic [31:0] GB       = 32'h7FFF_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [7:0]  gpio_in = 8'd0;
  logic [7:0]  gpio_out;
`ifdef GPIO_EDGE_CAPTURE_EN
  logic        irq;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] ram_m [int];
  int          written_q [$];
  logic [7:0]  gout_m = 8'd0;

  mem_gpio_responder #(.WAIT_CYC(WAIT_CYC)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .gpio_in    (gpio_in),
`ifdef GPIO_EDGE_CAPTURE_EN
    .irq        (irq),
`endif
    .gpio_out   (gpio_out)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  // One transaction; lat = edges from accept to resp_valid (99 if none), low = cycles with req_ready low.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic er, output int lat, output int low);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 0; low = 0; rd = 32'd0; er = 1'b0;
    while (!resp_valid && lat < 40) begin
      if (!req_ready) low++;
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) lat = 99;
    else begin
      rd = resp_rdata;
      er = resp_err;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp += 5;
    if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", resp_valid); end
    if (resp_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
    if (resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", resp_err); end
    if (gpio_out !== 8'd0) begin n_bad++; $display("FAIL reset_gpio_out: got %h want 0", gpio_out); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_after: got %b want 1", req_ready); end
  endtask

  task automatic test_ram_basic;
    logic [31:0] rd; logic er; int lat, low;
    txn(1'b1, 32'h0000_0040, 32'h1234_5678, rd, er, lat, low);
    ram_m[16] = 32'h1234_5678; written_q.push_back(16);
    n_cmp += 4;
    if (lat !== LAT_EXP) begin n_bad++; $display("FAIL ram_wr_lat: got %0d want %0d", lat, LAT_EXP); end
    if (er !== 1'b0) begin n_bad++; $display("FAIL ram_wr_err: got %b want 0", er); end
    if (rd !== 32'd0) begin n_bad++; $display("FAIL ram_wr_rdata: got %h want 0", rd); end
    if (low !== LAT_EXP) begin n_bad++; $display("FAIL ram_wr_ready_low: got %0d want %0d", low, LAT_EXP); end
    @(negedge clk);
    n_cmp++;
    if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL ram_wr_single_pulse: got %b want 0", resp_valid); end
    txn(1'b0, 32'h0000_0042, 32'd0, rd, er, lat, low);
    n_cmp += 4;
    if (rd !== 32'h1234_5678) begin n_bad++; $display("FAIL ram_rd_data: got %h want 12345678", rd); end
    if (er !== 1'b0) begin n_bad++; $display("FAIL ram_rd_err: got %b want 0", er); end
    if (lat !== LAT_EXP) begin n_bad++; $display("FAIL ram_rd_lat: got %0d want %0d", lat, LAT_EXP); end
    if (low !== LAT_EXP) begin n_bad++; $display("FAIL ram_rd_ready_low: got %0d want %0d", low, LAT_EXP); end
  endtask

  task automatic test_gpio_out;
    logic [31:0] rd; logic er; int lat, low;
    txn(1'b1, GB + 32'd4, 32'h0000_00A5, rd, er, lat, low);
    gout_m = 8'hA5;
    @(negedge clk);
    n_cmp += 2;
    if (gpio_out !== gout_m) begin n_bad++; $display("FAIL gout_after_write: got %h want %h", gpio_out, gout_m); end
    if (er !== 1'b0) begin n_bad++; $display("FAIL gout_wr_err: got %b want 0", er); end
    txn(1'b0, GB + 32'd4, 32'd0, rd, er, lat, low);
    n_cmp++;
    if (rd !== 32'h0000_00A5) begin n_bad++; $display("FAIL gout_readback: got %h want 000000a5", rd); end
  endtask

  task automatic test_gpio_in;
    logic [31:0] rd; logic er; int lat, low;
    gpio_in = 8'h3C;
    repeat (3) @(negedge clk);
    txn(1'b0, GB, 32'd0, rd, er, lat, low);
    n_cmp += 2;
    if (rd !== 32'h0000_003C) begin n_bad++; $display("FAIL gin_read: got %h want 0000003c", rd); end
    if (er !== 1'b0) begin n_bad++; $display("FAIL gin_read_err: got %b want 0", er); end
    txn(1'b1, GB, 32'h0000_00FF, rd, er, lat, low);
    n_cmp++;
    if (er !== 1'b0) begin n_bad++; $display("FAIL gin_write_err: got %b want 0", er); end
    txn(1'b0, GB, 32'd0, rd, er, lat, low);
    n_cmp += 2;
    if (rd !== 32'h0000_003C) begin n_bad++; $display("FAIL gin_after_write: got %h want 0000003c", rd); end
    if (gpio_out !== gout_m) begin n_bad++; $display("FAIL gin_write_gout: got %h want %h", gpio_out, gout_m); end
  endtask

  task automatic test_unmapped;
    logic [31:0] rd; logic er; int lat, low;
    txn(1'b0, 32'h4000_0000, 32'd0, rd, er, lat, low);
    n_cmp += 3;
    if (er !== 1'b1) begin n_bad++; $display("FAIL unmapped_err: got %b want 1", er); end
    if (rd !== 32'd0) begin n_bad++; $display("FAIL unmapped_rdata: got %h want 0", rd); end
    if (lat !== LAT_EXP) begin n_bad++; $display("FAIL unmapped_lat: got %0d want %0d", lat, LAT_EXP); end
    txn(1'b1, 32'h0000_0400, 32'hDEAD_BEEF, rd, er, lat, low);
    n_cmp++;
    if (er !== 1'b1) begin n_bad++; $display("FAIL ram_limit_err: got %b want 1", er); end
    txn(1'b1, GB + 32'd12, 32'h0000_0011, rd, er, lat, low);
    n_cmp += 2;
    if (er !== 1'b1) begin n_bad++; $display("FAIL gpio_hole_err: got %b want 1", er); end
    if (gpio_out !== gout_m) begin n_bad++; $display("FAIL unmapped_gout: got %h want %h", gpio_out, gout_m); end
    txn(1'b0, 32'h0000_0040, 32'd0, rd, er, lat, low);
    n_cmp++;
    if (rd !== ram_m[16]) begin n_bad++; $display("FAIL unmapped_ram_kept: got %h want %h", rd, ram_m[16]); end
`ifndef GPIO_EDGE_CAPTURE_EN
    txn(1'b0, GB + 32'd8, 32'd0, rd, er, lat, low);
    n_cmp++;
    if (er !== 1'b1) begin n_bad++; $display("FAIL edge_reg_absent: got %b want 1", er); end
`endif
  endtask

`ifdef GPIO_EDGE_CAPTURE_EN
  task automatic test_edge;
    logic [31:0] rd; logic er; int lat, low;
    gpio_in = 8'h00;
    repeat (4) @(negedge clk);
    txn(1'b1, GB + 32'd8, 32'h0000_00FF, rd, er, lat, low);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL edge_irq_clear0: got %b want 0", irq); end
    gpio_in = 8'h04;
    repeat (4) @(negedge clk);
    txn(1'b0, GB + 32'd8, 32'd0, rd, er, lat, low);
    n_cmp += 2;
    if (rd !== 32'h0000_0004) begin n_bad++; $display("FAIL edge_capture: got %h want 00000004", rd); end
    if (irq !== 1'b1) begin n_bad++; $display("FAIL edge_irq_set: got %b want 1", irq); end
    txn(1'b1, GB + 32'd8, 32'h0000_0004, rd, er, lat, low);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL edge_irq_cleared: got %b want 0", irq); end
    txn(1'b0, GB + 32'd8, 32'd0, rd, er, lat, low);
    n_cmp++;
    if (rd !== 32'd0) begin n_bad++; $display("FAIL edge_w1c: got %h want 0", rd); end
  endtask
`endif

  task automatic test_hold_request;
    int resp_n, guard; logic [31:0] rd;
    resp_n = 0; guard = 0; rd = 32'd0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0040; req_wdata = 32'd0;
    @(negedge clk);
    while (!resp_valid && guard < 40) begin
      req_write = 1'b1; req_addr = GB + 32'd4; req_wdata = $urandom;
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b0;
    if (resp_valid) begin resp_n++; rd = resp_rdata; end
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) resp_n++;
    end
    n_cmp += 3;
    if (resp_n !== 1) begin n_bad++; $display("FAIL hold_resp_count: got %0d want 1", resp_n); end
    if (rd !== ram_m[16]) begin n_bad++; $display("FAIL hold_latched_addr: got %h want %h", rd, ram_m[16]); end
    if (gpio_out !== gout_m) begin n_bad++; $display("FAIL hold_no_write: got %h want %h", gpio_out, gout_m); end
  endtask

  task automatic test_back_to_back;
    int idx_q [$]; int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    req_valid = 1'b1; req_write = 1'b0; req_addr = GB + 32'd4;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        idx_q.push_back(i);
        n_cmp++;
        if (resp_rdata !== {24'd0, gout_m}) begin
          n_bad++; $display("FAIL b2b_data: got %h want %h", resp_rdata, {24'd0, gout_m});
        end
      end
    end
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (idx_q.size() < 4) begin n_bad++; $display("FAIL b2b_count: got %0d want >=4", idx_q.size()); end
    for (int i = 1; i < idx_q.size(); i++) begin
      n_cmp++;
      if (idx_q[i] - idx_q[i-1] !== GAP_EXP) begin
        n_bad++; $display("FAIL b2b_spacing: got %0d want %0d", idx_q[i] - idx_q[i-1], GAP_EXP);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] rd, a, d, exp_rd; logic er, w, exp_er, chk_rd; int lat, low, word, kind;
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 4);
      w = 1'($urandom); d = $urandom; exp_er = 1'b0; exp_rd = 32'd0; chk_rd = 1'b1;
      case (kind)
        0: begin
          word = $urandom_range(0, 255);
          a = 32'(word) * 32'd4 + 32'($urandom_range(0, 3));
          if (w) begin
            ram_m[word] = d; written_q.push_back(word);
          end else if (ram_m.exists(word)) exp_rd = ram_m[word];
          else chk_rd = 1'b0;
        end
        1: begin
          word = written_q[$urandom_range(0, written_q.size() - 1)];
          a = 32'(word) * 32'd4; w = 1'b0; exp_rd = ram_m[word];
        end
        2: begin
          a = GB + 32'd4 + 32'($urandom_range(0, 3));
          if (w) gout_m = d[7:0];
          else exp_rd = {24'd0, gout_m};
        end
        3: begin
          gpio_in = 8'($urandom);
          repeat (3) @(negedge clk);
          a = GB + 32'($urandom_range(0, 3));
          if (!w) exp_rd = {24'd0, gpio_in};
        end
        default: begin
          a = (it % 2 == 0) ? (32'h8000_0000 | $urandom) : (32'h0000_0400 + 32'($urandom_range(0, 255)));
          exp_er = 1'b1;
        end
      endcase
      txn(w, a, d, rd, er, lat, low);
      n_cmp += 2;
      if (lat !== LAT_EXP) begin n_bad++; $display("FAIL rnd_lat[%0d]: got %0d want %0d", it, lat, LAT_EXP); end
      if (er !== exp_er) begin n_bad++; $display("FAIL rnd_err[%0d] a=%h: got %b want %b", it, a, er, exp_er); end
      if (chk_rd) begin
        n_cmp++;
        if (rd !== exp_rd) begin n_bad++; $display("FAIL rnd_rdata[%0d] a=%h: got %h want %h", it, a, rd, exp_rd); end
      end
      @(negedge clk);
      n_cmp++;
      if (gpio_out !== gout_m) begin n_bad++; $display("FAIL rnd_gout[%0d]: got %h want %h", it, gpio_out, gout_m); end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic er; int lat, low, seen, guard;
    txn(1'b1, 32'h0000_0080, 32'hCAFE_0020, rd, er, lat, low);
    ram_m[32] = 32'hCAFE_0020;
    for (int k = 0; k < 2; k++) begin
      seen = 0; guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
      req_valid = 1'b1; req_write = 1'b1;
      req_addr = (k == 0) ? (GB + 32'd4) : 32'h0000_0080;
      req_wdata = (k == 0) ? 32'h0000_005A : 32'h0BAD_0BAD;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; reset = 1'b1;
      @(negedge clk);
      if (resp_valid) seen++;
      reset = 1'b0;
      repeat (6) begin
        @(negedge clk);
        if (resp_valid) seen++;
      end
      gout_m = 8'd0;
      n_cmp += 2;
      if (seen !== 0) begin n_bad++; $display("FAIL rst_mid_resp[%0d]: got %0d want 0", k, seen); end
      if (gpio_out !== 8'd0) begin n_bad++; $display("FAIL rst_mid_gout[%0d]: got %h want 0", k, gpio_out); end
    end
    txn(1'b0, 32'h0000_0080, 32'd0, rd, er, lat, low);
    n_cmp++;
    if (rd !== ram_m[32]) begin n_bad++; $display("FAIL rst_mid_ram: got %h want %h", rd, ram_m[32]); end
  endtask

  initial begin
    test_reset();
    test_ram_basic();
    test_gpio_out();
    test_gpio_in();
    test_unmapped();
`ifdef GPIO_EDGE_CAPTURE_EN
    test_edge();
`endif
    test_hold_request();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_gpio_responder.md
Name: mem_gpio_responder

Overview:
Memory-mapped responder at the far end of the multicycle core's memory interface. It services word read/write requests from the core's fetch and data path and decodes each address to an internal word RAM, a GPIO input port, or a GPIO output register. It answers every accepted request with exactly one response after a programmable number of wait states. It sits between the core's memory port and the board switches and LEDs.

Parameters:
ADDR_W, 8, RAM word-address width; RAM depth = 2**ADDR_W words
DATA_W, 32, data width
WAIT_CYC, 1, extra cycles between accept and response (0..15)
GPIO_W, 8, GPIO input/output width
GPIO_BASE, 32'h7FFF_0000, base byte address of the GPIO window

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_write  in  1  1 = write, 0 = read
req_addr  in  32  byte address; bits [1:0] ignored
req_wdata  in  DATA_W  write data
resp_valid  out  1  one-cycle response strobe
resp_rdata  out  DATA_W  read data; 0 for writes and errors
resp_err  out  1  unmapped address; valid with resp_valid
gpio_in  in  GPIO_W  asynchronous switch inputs
gpio_out  out  GPIO_W  LED register

Behaviour:
- Reset values: req_ready=0 in the reset cycle, then 1. resp_valid=0, resp_rdata=0, resp_err=0, gpio_out=0, FSM=IDLE, both synchronizer stages=0. RAM contents are not reset.
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch write, addr and wdata, then go to WAIT if WAIT_CYC>0, otherwise go to RESP.
  - WAIT: counter loads WAIT_CYC-1 and counts down. Go to RESP when the counter reaches 0.
  - RESP: perform the access. Drive resp_valid=1 for exactly one cycle with the registered rdata and err. Return to IDLE.
- Handshake and latency:
  - A request is accepted only when req_valid && req_ready.
  - req_ready=0 in WAIT and RESP. No second outstanding request.
  - Latency from the accept edge to resp_valid = WAIT_CYC+1 cycles.
  - Back-to-back requests are accepted one per (WAIT_CYC+2) cycles.
  - Request inputs are ignored while not ready. The latched copy is used, so input changes mid-transaction have no effect.
- Address decode on the latched address:
  - RAM: addr < 4*2**ADDR_W. Index = addr[ADDR_W+1:2].
  - GPIO_IN: addr == GPIO_BASE. Read-only. Reads return the zero-extended synchronized value; writes are ignored with err=0.
  - GPIO_OUT: addr == GPIO_BASE+4. Read/write. A write stores wdata[GPIO_W-1:0]. A read returns gpio_out zero-extended.
  - Anything else: resp_err=1, rdata=0, no state change.
- The RAM is written in RESP only, so a write commits at the same edge that raises resp_valid.
- gpio_in passes through a 2-flop synchronizer. A GPIO_IN read returns the second-stage value sampled in RESP.
- The wait counter is 4 bits. WAIT_CYC>15 is illegal and must be blocked by an elaboration-time check.
- Reset asserted mid-transaction:
  - Abort to IDLE with no response.
  - A pending write is discarded and gpio_out is cleared.
  - RAM is unchanged except by a write already committed in a RESP before reset.

Optional Feature:
GPIO_EDGE_CAPTURE_EN
- Defined:
  - Adds a sticky rising-edge capture register at GPIO_BASE+8. Bit i sets when synchronized gpio_in[i] goes 0->1.
  - A read returns the register. A write clears the bits that are 1 in wdata (write-1-to-clear).
  - A set and a clear hitting the same bit in the same cycle leave it set.
  - Adds output irq (1 bit) = OR of the capture bits, registered. Reset value 0.
- Undefined: GPIO_BASE+8 decodes as unmapped (resp_err=1) and there is no irq port.

Decomposition:
- Shared package (mem_map_pkg) holds:
  - the FSM state encoding (IDLE/WAIT/RESP, 2 bits)
  - GPIO_BASE and the register offsets GPIO_IN_OFS=0, GPIO_OUT_OFS=4, GPIO_EDGE_OFS=8
  - the RAM region limit function
  - these are shared with the core's address generation
- One natural sub-module: gpio_sync_capture. It contains the 2-flop synchronizer, the edge detector and the capture register. The capture logic is present only under the macro.

Test Plan:
- Reset then read RAM word 0x10 after writing 0x1234_5678, with WAIT_CYC=1 -> write resp_valid 2 cycles after accept, err=0; read returns 0x1234_5678, err=0; req_ready low for exactly 2 cycles per transaction.
- Write 0x0000_00A5 to 0x7FFF_0004, then read it back -> gpio_out=0xA5 the cycle after the write's resp_valid; read returns 0x0000_00A5.
- Drive gpio_in=0x3C and wait 3 cycles, then read 0x7FFF_0000 -> rdata 0x0000_003C. Write 0xFF to the same address -> err=0 and gpio_in readback is unchanged.
- Read 0x4000_0000 -> resp_valid with err=1, rdata=0; RAM and gpio_out unchanged.
- Hold req_valid for 10 cycles while changing req_addr during WAIT -> exactly one response, using the accept-cycle address. Assert reset during WAIT of a write to 0x7FFF_0004 -> no resp_valid, gpio_out=0.
- With GPIO_EDGE_CAPTURE_EN: pulse gpio_in[2] 0->1 -> read 0x7FFF_0008 gives 0x4 and irq=1. Write 0x4 -> register 0 and irq=0 one cycle later.
